mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-002 Rst  in  1  reset; SHALL be synchronous and active-high.
REQ-003 RdWriteDataIn  in  `DataBus (64)  EX result, passed through for non-memory ops.
REQ-004 RdAddrIn  in  `RegFileAddr (5)  destination register.
REQ-005 RdWriteEnableIn  in  1  destination write request.
REQ-006 ImmIn  in  64  address offset.
REQ-007 OpCodeIn  in  7  instruction opcode.
REQ-008 Funct3In  in  3  access size/sign.
REQ-009 Rs1ReadDataIn  in  64  address base.
REQ-010 Rs2ReadDataIn  in  64  store data.
REQ-011 MemReqValid  out  1  memory request valid.
REQ-012 MemReqReady  in  1  memory accepts request.
REQ-013 MemAddr  out  64  doubleword-aligned address.
REQ-014 MemWriteEnable  out  1  1=store, 0=load.
REQ-015 MemWriteData  out  64  lane-shifted store data.
REQ-016 MemWriteMask  out  8  byte-lane enables.
REQ-017 MemRespValid  in  1  load data valid.
REQ-018 MemReadData  in  64  load doubleword.
REQ-019 RdWriteDataOut  out  64  writeback data.
REQ-020 RdAddrOut  out  5  equals RdAddrIn.
REQ-021 RdWriteEnableOut  out  1  writeback enable.
REQ-022 MemStall  out  1  upstream SHALL hold all inputs stable while 1.
REQ-023 MisalignOut  out  1  misaligned-access pulse (see Configuration).

Function
REQ-024 Load = OpCodeIn 0000011, store = 0100011; all other opcodes SHALL pass through combinationally: RdWriteDataOut=RdWriteDataIn, RdWriteEnableOut=RdWriteEnableIn, MemStall=0, zero latency.
REQ-025 EA = Rs1ReadDataIn + ImmIn, modulo 2^64; MemAddr = EA with bits [2:0] cleared; off = EA[2:0].
REQ-026 Size from Funct3[1:0]: 00 byte, 01 half, 10 word, 11 double; MemWriteMask = size mask << off, truncated to 8 bits; MemWriteData = Rs2ReadDataIn << (8*off).
REQ-027 Load data = MemReadData >> (8*off), then sign-extended for Funct3 000/001/010, zero-extended for 100/101/110; 011 and 111 SHALL be treated as full 64-bit.
REQ-028 FSM states IDLE, REQ, WAIT, DONE; MemStall=1 in IDLE (when a memory op is present), REQ and WAIT; MemStall=0 in DONE.
REQ-029 IDLE: memory op present -> REQ; otherwise stay.
REQ-030 REQ: MemReqValid=1 with MemAddr/MemWriteEnable/MemWriteData/MemWriteMask stable until MemReqReady; on MemReqReady, store -> DONE, load -> WAIT.
REQ-031 WAIT: on MemRespValid, capture extended load data into a 64-bit register -> DONE; MemRespValid SHALL be ignored in all other states.
REQ-032 DONE: load -> RdWriteDataOut = captured data, RdWriteEnableOut = RdWriteEnableIn; store -> RdWriteEnableOut=0; unconditional -> IDLE.
REQ-033 Minimum stall: store 2 cycles, load 3 cycles (ready and response each in first possible cycle); no upper bound.
REQ-034 MemReqValid SHALL never deassert in REQ before MemReqReady.

Reset
REQ-035 Rst=1 SHALL force IDLE, MemReqValid=0, MisalignOut=0, captured-load register=0 at the next edge, including mid REQ/WAIT; responses arriving afterwards SHALL be discarded.
REQ-036 While in IDLE after reset with no memory op: MemStall=0, RdWriteDataOut=RdWriteDataIn, RdWriteEnableOut=RdWriteEnableIn.

Configuration
REQ-037 Macro MEM_MISALIGN_CHECK_EN defined: a half/word/double access with EA not naturally aligned SHALL issue no request, SHALL not stall, SHALL force RdWriteEnableOut=0, and SHALL pulse MisalignOut=1 for exactly one cycle.
REQ-038 Macro undefined: MisalignOut SHALL be constant 0 and misaligned accesses SHALL proceed per REQ-026/027, with bytes beyond the doubleword dropped.

Verification
REQ-039 ADD passthrough, RdWriteDataIn=0x1234 -> RdWriteDataOut=0x1234 same cycle, MemStall=0, MemReqValid never 1.
REQ-040 SB: Rs1=0x1000, Imm=3, Rs2=0xAB, MemReqReady=1 -> MemAddr=0x1000, mask=0x08, data[31:24]=0xAB, MemStall=1 for 2 cycles, RdWriteEnableOut=0.
REQ-041 LB: EA=0x2005, MemReadData byte5=0x80 -> RdWriteDataOut=0xFFFFFFFFFFFFFF80; LBU -> 0x80; stall 3 cycles.
REQ-042 LD with MemReqReady low for 4 cycles -> MemReqValid and address held stable 4 cycles, stall extends by 4.
REQ-043 Rst asserted in WAIT, MemRespValid arrives next cycle -> state IDLE, no writeback, MemReqValid=0.
REQ-044 MEM_MISALIGN_CHECK_EN defined, LW at EA=0x3002 -> MisalignOut=1 for one cycle, no request, RdWriteEnableOut=0.

Source files
------------

// File: rtl/mem_access_if.sv
// Memory-side request/response bundle for mem_access_unit.
// master: the access unit issuing requests; slave: the memory answering them.
interface mem_access_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;

    logic              MemReqValid;
    logic              MemReqReady;
    logic [DATA_W-1:0] MemAddr;
    logic              MemWriteEnable;
    logic [DATA_W-1:0] MemWriteData;
    logic [MASK_W-1:0] MemWriteMask;
    logic              MemRespValid;
    logic [DATA_W-1:0] MemReadData;

    modport master (
        output MemReqValid, MemAddr, MemWriteEnable, MemWriteData, MemWriteMask,
        input  MemReqReady, MemRespValid, MemReadData
    );

    modport slave (
        input  MemReqValid, MemAddr, MemWriteEnable, MemWriteData, MemWriteMask,
        output MemReqReady, MemRespValid, MemReadData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: issues one doubleword memory access per load/store and stalls until done.
// Optional macro MEM_MISALIGN_CHECK_EN traps misaligned half/word/double accesses.
module mem_access_unit #(
    localparam int unsigned DATA_W     = 64,
    localparam int unsigned REG_ADDR_W = 5,
    localparam int unsigned OP_W       = 7
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_W-1:0]     RdWriteDataIn,
    input  logic [REG_ADDR_W-1:0] RdAddrIn,
    input  logic                  RdWriteEnableIn,
    input  logic [DATA_W-1:0]     ImmIn,
    input  logic [OP_W-1:0]       OpCodeIn,
    input  logic [2:0]            Funct3In,
    input  logic [DATA_W-1:0]     Rs1ReadDataIn,
    input  logic [DATA_W-1:0]     Rs2ReadDataIn,
    mem_access_if.master          mem,
    output logic [DATA_W-1:0]     RdWriteDataOut,
    output logic [REG_ADDR_W-1:0] RdAddrOut,
    output logic                  RdWriteEnableOut,
    output logic                  MemStall,
    output logic                  MisalignOut
);

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;

    logic              is_load, is_store, is_mem;
    logic [DATA_W-1:0] ea;
    logic [2:0]        off;
    logic [5:0]        shamt;
    logic [7:0]        size_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;

    assign is_load  = (OpCodeIn == OP_LOAD);
    assign is_store = (OpCodeIn == OP_STORE);
    assign is_mem   = is_load | is_store;

    // Address split: doubleword-aligned bus address plus byte lane offset
    assign ea    = Rs1ReadDataIn + ImmIn;
    assign off   = ea[2:0];
    assign shamt = {off, 3'b000};

    always_comb begin
        case (Funct3In[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign mem.MemAddr        = {ea[DATA_W-1:3], 3'b000};
    assign mem.MemWriteEnable = is_store;
    assign mem.MemWriteData   = Rs2ReadDataIn << shamt;
    assign mem.MemWriteMask   = size_mask << off;
    assign RdAddrOut          = RdAddrIn;

    // Lane-align returned doubleword, then sign/zero extend by access size
    assign shifted = mem.MemReadData >> shamt;

    always_comb begin
        case (Funct3In)
            3'b000:  ext = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  ext = {56'd0, shifted[7:0]};
            3'b101:  ext = {48'd0, shifted[15:0]};
            3'b110:  ext = {32'd0, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q, misalign_d;

    always_comb begin
        case (Funct3In[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    end

    assign MisalignOut = misalign_q;
`else
    assign MisalignOut = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            load_data_q <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Next state and handshake/writeback outputs
    always_comb begin
        state_d          = state_q;
        load_data_d      = load_data_q;
        mem.MemReqValid  = 1'b0;
        MemStall         = 1'b0;
        RdWriteDataOut   = RdWriteDataIn;
        RdWriteEnableOut = RdWriteEnableIn;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    RdWriteEnableOut = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        MemStall = 1'b1;
                        state_d  = S_REQ;
                    end
`else
                    MemStall = 1'b1;
                    state_d  = S_REQ;
`endif
                end
            end
            S_REQ: begin
                MemStall         = 1'b1;
                RdWriteEnableOut = 1'b0;
                mem.MemReqValid  = 1'b1;
                if (mem.MemReqReady) begin
                    state_d = is_store ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                MemStall         = 1'b1;
                RdWriteEnableOut = 1'b0;
                if (mem.MemRespValid) begin
                    load_data_d = ext;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (is_store) begin
                    RdWriteEnableOut = 1'b0;
                end else begin
                    RdWriteDataOut = load_data_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-level reference model and a reactive memory.
// Define MEM_MISALIGN_CHECK_EN to exercise the misalignment trap instead of pass-through.
module tb_mem_access_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        clk;
    logic        rst;
    logic [63:0] rd_wdata_in;
    logic [4:0]  rd_addr_in;
    logic        rd_we_in;
    logic [63:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rd_wdata_out;
    logic [4:0]  rd_addr_out;
    logic        rd_we_out;
    logic        stall;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_if mem_bus ();

    mem_access_unit dut (
        .Clk              (clk),
        .Rst              (rst),
        .RdWriteDataIn    (rd_wdata_in),
        .RdAddrIn         (rd_addr_in),
        .RdWriteEnableIn  (rd_we_in),
        .ImmIn            (imm),
        .OpCodeIn         (opcode),
        .Funct3In         (funct3),
        .Rs1ReadDataIn    (rs1),
        .Rs2ReadDataIn    (rs2),
        .mem              (mem_bus),
        .RdWriteDataOut   (rd_wdata_out),
        .RdAddrOut        (rd_addr_out),
        .RdWriteEnableOut (rd_we_out),
        .MemStall         (stall),
        .MisalignOut      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: byte-by-byte view of the access
    function automatic int access_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] model_mask(input logic [2:0] off, input logic [2:0] f3);
        logic [7:0] m;
        m = '0;
        for (int b = 0; b < 8; b++)
            if (b >= int'(off) && b < int'(off) + access_bytes(f3)) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [2:0] off);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < 8; b++)
            if (b >= int'(off)) w[8*b +: 8] = d[8*(b - int'(off)) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdat, input logic [2:0] off,
                                               input logic [2:0] f3);
        logic [63:0] v;
        int n;
        n = access_bytes(f3);
        v = '0;
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = rdat[8*(int'(off) + i) +: 8];
        if (!f3[2] && n < 8 && v[8*n - 1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    task automatic drive_nop(input logic [63:0] d, input logic we);
        opcode      = OP_ADD;
        funct3      = 3'b000;
        rd_wdata_in = d;
        rd_we_in    = we;
        rd_addr_in  = 5'd1;
        rs1         = '0;
        rs2         = '0;
        imm         = '0;
    endtask

    // One load/store driven to completion against a memory with the given latencies
    task automatic test_mem_op(input string name, input logic is_ld, input logic [2:0] f3,
                               input logic [63:0] a_rs1, input logic [63:0] a_imm,
                               input logic [63:0] a_rs2, input int ready_delay,
                               input int resp_delay, input logic [63:0] rdata);
        logic [63:0] ea;
        logic [2:0]  off;
        logic        we;
        logic [4:0]  rd;
        logic        acc;
        logic        done;
        int          stalls, rcnt, rspcnt, exp_stalls;
        ea  = a_rs1 + a_imm;
        off = ea[2:0];
        we  = 1'($urandom);
        rd  = 5'($urandom);
        @(posedge clk); #1;
        opcode      = is_ld ? OP_LOAD : OP_STORE;
        funct3      = f3;
        rs1         = a_rs1;
        imm         = a_imm;
        rs2         = a_rs2;
        rd_addr_in  = rd;
        rd_we_in    = we;
        rd_wdata_in = {$urandom, $urandom};
        mem_bus.MemReqReady  = 1'b0;
        mem_bus.MemRespValid = 1'b0;
        acc = 1'b0; done = 1'b0;
        stalls = 0; rcnt = 0; rspcnt = 0;
        exp_stalls = is_ld ? 3 + ready_delay + resp_delay : 2 + ready_delay;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_bus.MemReqValid) begin
                    n_checks++;
                    if (mem_bus.MemAddr !== {ea[63:3], 3'b000} || mem_bus.MemWriteEnable !== !is_ld
                        || mem_bus.MemWriteMask !== model_mask(off, f3)
                        || mem_bus.MemWriteData !== model_wdata(a_rs2, off)) begin
                        n_fail++;
                        $display("FAIL %s req: addr=%h we=%b mask=%h data=%h required addr=%h we=%b mask=%h data=%h",
                                 name, mem_bus.MemAddr, mem_bus.MemWriteEnable, mem_bus.MemWriteMask,
                                 mem_bus.MemWriteData, {ea[63:3], 3'b000}, !is_ld,
                                 model_mask(off, f3), model_wdata(a_rs2, off));
                    end
                    mem_bus.MemReqReady = (rcnt == ready_delay);
                    if (rcnt == ready_delay) acc = 1'b1;
                    rcnt++;
                    mem_bus.MemRespValid = 1'($urandom);
                    mem_bus.MemReadData  = {$urandom, $urandom};
                end else begin
                    mem_bus.MemReqReady = 1'b0;
                    if (acc && is_ld) begin
                        mem_bus.MemRespValid = (rspcnt == resp_delay);
                        mem_bus.MemReadData  = (rspcnt == resp_delay) ? rdata : {$urandom, $urandom};
                        rspcnt++;
                    end else begin
                        mem_bus.MemRespValid = 1'($urandom);
                        mem_bus.MemReadData  = {$urandom, $urandom};
                    end
                end
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: stall still %b after 100 cycles, required 0", name, stall);
        end else if (stalls != exp_stalls || rd_we_out !== (is_ld ? we : 1'b0)
                     || rd_addr_out !== rd || mem_bus.MemReqValid !== 1'b0 || misalign !== 1'b0
                     || (is_ld && rd_wdata_out !== model_load(rdata, off, f3))) begin
            n_fail++;
            $display("FAIL %s done: stalls=%0d we=%b rd=%0d data=%h valid=%b mis=%b required stalls=%0d we=%b rd=%0d data=%h valid=0 mis=0",
                     name, stalls, rd_we_out, rd_addr_out, rd_wdata_out, mem_bus.MemReqValid,
                     misalign, exp_stalls, is_ld ? we : 1'b0, rd,
                     is_ld ? model_load(rdata, off, f3) : rd_wdata_out);
        end
        mem_bus.MemReqReady  = 1'b0;
        mem_bus.MemRespValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_nop(64'hCAFE_F00D, 1'b1);
        mem_bus.MemReqReady  = 1'b0;
        mem_bus.MemRespValid = 1'b0;
        mem_bus.MemReadData  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_bus.MemReqValid !== 1'b0 || stall !== 1'b0 || misalign !== 1'b0
            || rd_wdata_out !== 64'hCAFE_F00D || rd_we_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b stall=%b mis=%b data=%h we=%b required 0 0 0 cafef00d 1",
                     mem_bus.MemReqValid, stall, misalign, rd_wdata_out, rd_we_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [63:0] d;
        logic        we;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            d  = (i == 0) ? 64'h1234 : {$urandom, $urandom};
            we = (i == 0) ? 1'b1 : 1'($urandom);
            drive_nop(d, we);
            opcode = (i == 0) ? OP_ADD : 7'($urandom);
            if (opcode == OP_LOAD || opcode == OP_STORE) opcode = OP_ADD;
            #1;
            n_checks++;
            if (rd_wdata_out !== d || rd_we_out !== we || stall !== 1'b0 || mem_bus.MemReqValid !== 1'b0) begin
                n_fail++;
                $display("FAIL passthrough[%0d]: data=%h we=%b stall=%b valid=%b required %h %b 0 0",
                         i, rd_wdata_out, rd_we_out, stall, mem_bus.MemReqValid, d, we);
            end
            @(negedge clk);
            n_checks++;
            if (mem_bus.MemReqValid !== 1'b0 || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL passthrough_hold[%0d]: valid=%b stall=%b required 0 0",
                         i, mem_bus.MemReqValid, stall);
            end
        end
    endtask

    task automatic test_store_byte();
        test_mem_op("sb", 1'b0, 3'b000, 64'h1000, 64'd3, 64'hAB, 0, 0, '0);
    endtask

    task automatic test_load_byte();
        logic [63:0] rdat;
        rdat = 64'h1122_8044_5566_7788;
        test_mem_op("lb",  1'b1, 3'b000, 64'h2000, 64'd5, 64'h0, 0, 0, rdat);
        test_mem_op("lbu", 1'b1, 3'b100, 64'h2000, 64'd5, 64'h0, 0, 0, rdat);
    endtask

    task automatic test_backpressure();
        test_mem_op("ld_bp", 1'b1, 3'b011, 64'h5000, 64'h8, 64'h0, 4, 0, 64'hDEAD_BEEF_0BAD_F00D);
        test_mem_op("sd_bp", 1'b0, 3'b011, 64'h5000, 64'h10, 64'h0123_4567_89AB_CDEF, 3, 0, '0);
        test_mem_op("lw_slowresp", 1'b1, 3'b010, 64'h6000, 64'h4, 64'h0, 1, 5, 64'h8765_4321_0000_0000);
    endtask

    task automatic test_back_to_back();
        logic        is_ld;
        logic [2:0]  f3;
        logic [63:0] a_rs1, a_imm, ea;
        for (int i = 0; i < 30; i++) begin
            is_ld = 1'($urandom);
            f3    = is_ld ? 3'($urandom) : {1'b0, 2'($urandom)};
            a_rs1 = {$urandom, $urandom};
            a_imm = 64'($urandom_range(0, 64)) - 64'd32;
            ea    = a_rs1 + a_imm;
`ifdef MEM_MISALIGN_CHECK_EN
            a_imm = a_imm - (ea % 64'(access_bytes(f3)));
`endif
            test_mem_op("rand", is_ld, f3, a_rs1, a_imm, {$urandom, $urandom},
                        $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        opcode = OP_LOAD; funct3 = 3'b011; rs1 = 64'h4000; imm = '0; rd_we_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_bus.MemReqValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_req: valid=%b required 1", mem_bus.MemReqValid);
        end
        mem_bus.MemReqReady = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_bus.MemReqReady = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || mem_bus.MemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_inwait: stall=%b valid=%b required 1 0", stall, mem_bus.MemReqValid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_bus.MemRespValid = 1'b1;
        mem_bus.MemReadData  = 64'hBAD0_BAD0_BAD0_BAD0;
        drive_nop(64'h5A5A, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0 || mem_bus.MemReqValid !== 1'b0 || rd_wdata_out !== 64'h5A5A || rd_we_out !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_wait_after[%0d]: stall=%b valid=%b data=%h we=%b required 0 0 5a5a 1",
                         k, stall, mem_bus.MemReqValid, rd_wdata_out, rd_we_out);
            end
            @(posedge clk); #1;
            mem_bus.MemRespValid = 1'b0;
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
        @(posedge clk); #1;
        opcode = OP_LOAD; funct3 = 3'b010; rs1 = 64'h3000; imm = 64'd2; rd_we_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_bus.MemReqValid !== 1'b0 || rd_we_out !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_issue: stall=%b valid=%b we=%b required 0 0 0",
                     stall, mem_bus.MemReqValid, rd_we_out);
        end
        @(posedge clk); #1;
        drive_nop(64'h77, 1'b1);
        @(negedge clk);
        n_checks++;
        if (misalign !== 1'b1 || mem_bus.MemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse: mis=%b valid=%b required 1 0", misalign, mem_bus.MemReqValid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clear: mis=%b required 0", misalign);
        end
`else
        test_mem_op("lw_mis",  1'b1, 3'b010, 64'h3000, 64'd6, 64'h0, 0, 0, 64'hF1E2_D3C4_B5A6_9788);
        test_mem_op("sw_mis",  1'b0, 3'b010, 64'h3000, 64'd6, 64'hAABB_CCDD, 1, 0, '0);
        test_mem_op("lh_mis",  1'b1, 3'b001, 64'h3000, 64'd7, 64'h0, 0, 1, 64'h8000_0000_0000_0000);
        test_mem_op("sd_mis",  1'b0, 3'b011, 64'h3000, 64'd5, 64'h0102_0304_0506_0708, 0, 0, '0);
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store_byte();
        test_load_byte();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_misalign();
        @(posedge clk); #1;
        drive_nop('0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
